// File: rtl/register_with_freeze_and_flush.sv
`default_nettype none
// ============================================================================
// Module   : register_with_freeze_and_flush
// Brief    : WIDTH-bit pipeline register with hold (freeze) and synchronous
//            clear (flush); flush overrides freeze. Optional `valid` output
//            enabled by defining REG_FREEZE_FLUSH_VALID_EN.
// Revision : 1.0 - initial release
// ============================================================================
module register_with_freeze_and_flush #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] FLUSH_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic [WIDTH-1:0] in,
`ifdef REG_FREEZE_FLUSH_VALID_EN
    output logic             valid,
`endif
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r_data;

    // rst is active-low; flush takes precedence over freeze
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= RESET_VALUE;
        end else if (flush) begin
            r_data <= FLUSH_VALUE;
        end else if (!freeze) begin
            r_data <= in;
        end
    end

    assign out = r_data;

`ifdef REG_FREEZE_FLUSH_VALID_EN
    logic r_valid;

    // Marks non-bubble data; tracks the same priority as r_data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!freeze) begin
            r_valid <= 1'b1;
        end
    end

    assign valid = r_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_register_with_freeze_and_flush.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_with_freeze_and_flush
// Brief    : Directed self-checking bench for register_with_freeze_and_flush
//            (default 32-bit instance and an 8-bit instance with custom values).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_register_with_freeze_and_flush;

    logic        clk;
    logic        rst;
    logic        freeze, flush;
    logic [31:0] in32;
    logic [31:0] out32;
    logic        freeze8, flush8;
    logic [7:0]  in8;
    logic [7:0]  out8;
`ifdef REG_FREEZE_FLUSH_VALID_EN
    logic        valid32;
    logic        valid8;
`endif

    int errors = 0;
    int checks = 0;

    register_with_freeze_and_flush #(
        .WIDTH(32)
    ) u_dut32 (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .flush  (flush),
        .in     (in32),
`ifdef REG_FREEZE_FLUSH_VALID_EN
        .valid  (valid32),
`endif
        .out    (out32)
    );

    register_with_freeze_and_flush #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5),
        .FLUSH_VALUE (8'h3C)
    ) u_dut8 (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze8),
        .flush  (flush8),
        .in     (in8),
`ifdef REG_FREEZE_FLUSH_VALID_EN
        .valid  (valid8),
`endif
        .out    (out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive at negedge, then sample 1ns after the capturing posedge
    task automatic step(input logic fz, input logic fl, input logic [31:0] d);
        @(negedge clk);
        freeze = fz;
        flush  = fl;
        in32   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; in32 = 32'hDEADBEEF;
        freeze8 = 1'b0; flush8 = 1'b0; in8 = 8'h11;
        #1 rst = 1'b0;
        #1;
        check("reset_async", out32, 32'h0);
        check("reset_p8", {24'h0, out8}, 32'hA5);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_hold", out32, 32'h0);
        end
        check("reset_hold_p8", {24'h0, out8}, 32'hA5);
`ifdef REG_FREEZE_FLUSH_VALID_EN
        check("valid_reset", {31'h0, valid32}, 32'h0);
`endif

        // Load sequence
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'(4 * i));
            check("load", out32, 32'(4 * i));
        end
        @(negedge clk);
        check("stable_between_edges", out32, 32'hC);
`ifdef REG_FREEZE_FLUSH_VALID_EN
        check("valid_load", {31'h0, valid32}, 32'h1);
`endif

        // Freeze for 3 edges, then first unfrozen edge loads current in
        step(1'b0, 1'b0, 32'h10);
        check("load_10", out32, 32'h10);
        step(1'b1, 1'b0, 32'h14); check("freeze_1", out32, 32'h10);
        step(1'b1, 1'b0, 32'h18); check("freeze_2", out32, 32'h10);
        step(1'b1, 1'b0, 32'h1C); check("freeze_3", out32, 32'h10);
`ifdef REG_FREEZE_FLUSH_VALID_EN
        check("valid_freeze", {31'h0, valid32}, 32'h1);
`endif
        step(1'b0, 1'b0, 32'h20); check("unfreeze", out32, 32'h20);

        // Flush overrides freeze
        step(1'b0, 1'b0, 32'h12345678); check("load_pre_flush", out32, 32'h12345678);
        step(1'b1, 1'b1, 32'hAAAA5555); check("flush_over_freeze", out32, 32'h0);
`ifdef REG_FREEZE_FLUSH_VALID_EN
        check("valid_flush", {31'h0, valid32}, 32'h0);
`endif
        step(1'b0, 1'b0, 32'h9); check("reload", out32, 32'h9);
        step(1'b0, 1'b1, 32'h55); check("flush_only", out32, 32'h0);
        step(1'b0, 1'b1, 32'h56); check("flush_held", out32, 32'h0);
        step(1'b1, 1'b0, 32'h66); check("flush_then_freeze", out32, 32'h0);
`ifdef REG_FREEZE_FLUSH_VALID_EN
        check("valid_hold_after_flush", {31'h0, valid32}, 32'h0);
`endif
        step(1'b0, 1'b0, 32'h77); check("load_after_flush", out32, 32'h77);
`ifdef REG_FREEZE_FLUSH_VALID_EN
        check("valid_reload", {31'h0, valid32}, 32'h1);
`endif

        // Asynchronous reset mid-cycle, no clock edge needed
        #2 rst = 1'b0;
        #1 check("reset_midcycle", out32, 32'h0);
        check("reset_midcycle_p8", {24'h0, out8}, 32'hA5);
`ifdef REG_FREEZE_FLUSH_VALID_EN
        check("valid_midcycle_reset", {31'h0, valid32}, 32'h0);
`endif
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("no_restore", out32, 32'h77 & 32'h0 | in32);

        // Parameterised instance: flush, load, freeze
        @(negedge clk); flush8 = 1'b1; in8 = 8'h01;
        @(posedge clk); #1;
        check("p8_flush", {24'h0, out8}, 32'h3C);
        @(negedge clk); flush8 = 1'b0; in8 = 8'h7E;
        @(posedge clk); #1;
        check("p8_load", {24'h0, out8}, 32'h7E);
        @(negedge clk); freeze8 = 1'b1; in8 = 8'h42;
        @(posedge clk); #1;
        check("p8_freeze", {24'h0, out8}, 32'h7E);
        @(negedge clk); freeze8 = 1'b1; flush8 = 1'b1;
        @(posedge clk); #1;
        check("p8_flush_over_freeze", {24'h0, out8}, 32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
